// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply job scheduler and the core array.
//   - sched_state_e : scheduler FSM states
//   - DIM_W_DEF / CNT_W_DEF : default dimension and job-counter widths
//   - job_t : one job descriptor {row, col, len} as seen by a core
package matmul_pkg;

  localparam int DIM_W_DEF = 8;

  // Counters must hold M*N, the product of two DIM_W-bit dimensions.
  function automatic int cnt_w_for(input int dim_w);
    return 2 * dim_w;
  endfunction

  localparam int CNT_W_DEF = cnt_w_for(DIM_W_DEF);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_FINISH
  } sched_state_e;

  typedef struct packed {
    logic [DIM_W_DEF-1:0] row;
    logic [DIM_W_DEF-1:0] col;
    logic [DIM_W_DEF-1:0] len;
  } job_t;

endpackage

// File: rtl/rr_idle_picker.sv
// Round-robin first-idle selector.
// Scans busy_i starting at ptr_i, wrapping modulo N, and grants the first
// entry whose busy bit is clear.
//   busy_i       : per-entry busy flags
//   ptr_i        : scan start index (0..N-1)
//   grant_idx_o  : selected idle entry (valid only with grant_vld_o)
//   grant_vld_o  : at least one entry is idle
module rr_idle_picker #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     busy_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic             grant_vld_o
);

  int j;

  always_comb begin
    grant_vld_o = 1'b0;
    grant_idx_o = '0;
    j           = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      if (!grant_vld_o && !busy_i[j]) begin
        grant_vld_o = 1'b1;
        grant_idx_o = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/matmul_core_scheduler.sv
// Job scheduler for one C = A x B multiply spread over CORES MAC cores.
// Each C[row][col] is one job, issued row-major to idle cores picked
// round-robin; completions are counted until all M*N jobs are done.
//   CLOCK, RESET           : clock, asynchronous active-high reset
//   START, DIM_M/N/K       : job-set request and dimensions (sampled in IDLE)
//   DISP_VALID             : one-hot offer to core i
//   DISP_ROW/COL/LEN       : broadcast job index and latched K
//   CORE_READY, CORE_DONE  : per-core accept and completion pulse
//   BUSY, DONE, ERROR      : run status, completion pulse, protocol fault pulse
module matmul_core_scheduler
  import matmul_pkg::*;
#(
  parameter int CORES = 4,
  parameter int DIM_W = DIM_W_DEF,
  parameter int CNT_W = cnt_w_for(DIM_W)
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             START,
  input  logic [DIM_W-1:0] DIM_M,
  input  logic [DIM_W-1:0] DIM_N,
  input  logic [DIM_W-1:0] DIM_K,
  output logic [CORES-1:0] DISP_VALID,
  output logic [DIM_W-1:0] DISP_ROW,
  output logic [DIM_W-1:0] DISP_COL,
  output logic [DIM_W-1:0] DISP_LEN,
  input  logic [CORES-1:0] CORE_READY,
  input  logic [CORES-1:0] CORE_DONE,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERROR
);

  localparam int IDX_W = (CORES > 1) ? $clog2(CORES) : 1;
  localparam int PC_W  = $clog2(CORES + 1);

  sched_state_e      state_q;
  logic [CORES-1:0]  disp_vld_q, core_busy_q, core_busy_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [DIM_W-1:0]  row_q, col_q, n_q, k_q;
  logic [CNT_W-1:0]  total_q, issued_q, completed_q, completed_d;
  logic              run_q, done_q, err_q;

  logic [CORES-1:0]  xfer_vec, done_hit, done_bad, grant_oh;
  logic [IDX_W-1:0]  grant_idx, xfer_idx;
  logic              grant_vld, xfer, active;
  logic [PC_W-1:0]   done_cnt;

  rr_idle_picker #(
    .N     (CORES),
    .IDX_W (IDX_W)
  ) u_pick (
    .busy_i      (core_busy_q),
    .ptr_i       (ptr_q),
    .grant_idx_o (grant_idx),
    .grant_vld_o (grant_vld)
  );

  always_comb begin
    active   = (state_q != ST_IDLE);
    xfer_vec = disp_vld_q & CORE_READY;
    xfer     = |xfer_vec;
    // The offer is one-hot, so its set bit names the accepting core.
    xfer_idx = '0;
    grant_oh = '0;
    for (int i = 0; i < CORES; i++) begin
      if (disp_vld_q[i]) xfer_idx = IDX_W'(i);
      grant_oh[i] = (grant_idx == IDX_W'(i));
    end
    ptr_d = (int'(xfer_idx) == CORES - 1) ? '0 : xfer_idx + IDX_W'(1);

    done_hit = active ? (CORE_DONE & core_busy_q)  : '0;
    done_bad = active ? (CORE_DONE & ~core_busy_q) : '0;
    done_cnt = '0;
    for (int i = 0; i < CORES; i++) begin
      done_cnt = done_cnt + PC_W'(done_hit[i]);
    end
    // A done retires the old job before a same-cycle transfer re-arms busy.
    core_busy_d = (core_busy_q & ~done_hit) | xfer_vec;
    completed_d = completed_q + CNT_W'(done_cnt);
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      disp_vld_q  <= '0;
      core_busy_q <= '0;
      ptr_q       <= '0;
      row_q       <= '0;
      col_q       <= '0;
      n_q         <= '0;
      k_q         <= '0;
      total_q     <= '0;
      issued_q    <= '0;
      completed_q <= '0;
      run_q       <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      err_q       <= |done_bad;
      core_busy_q <= core_busy_d;
      completed_q <= completed_d;
      case (state_q)
        ST_IDLE: begin
          if (START) begin
            n_q     <= DIM_N;
            k_q     <= DIM_K;
            total_q <= CNT_W'(DIM_M) * CNT_W'(DIM_N);
            if (DIM_M == '0 || DIM_N == '0 || DIM_K == '0) begin
              err_q <= 1'b1;
            end else begin
              row_q       <= '0;
              col_q       <= '0;
              issued_q    <= '0;
              completed_q <= '0;
              run_q       <= 1'b1;
              state_q     <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (xfer) begin
            disp_vld_q <= '0;
            ptr_q      <= ptr_d;
            issued_q   <= issued_q + CNT_W'(1);
            if (col_q == n_q - DIM_W'(1)) begin
              col_q <= '0;
              row_q <= row_q + DIM_W'(1);
            end else begin
              col_q <= col_q + DIM_W'(1);
            end
            if (issued_q + CNT_W'(1) == total_q) state_q <= ST_DRAIN;
          end else if (disp_vld_q == '0 && grant_vld) begin
            disp_vld_q <= grant_oh;
          end
        end
        ST_DRAIN: begin
          if (completed_q == total_q) begin
            done_q  <= 1'b1;
            run_q   <= 1'b0;
            state_q <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign DISP_VALID = disp_vld_q;
  assign DISP_ROW   = row_q;
  assign DISP_COL   = col_q;
  assign DISP_LEN   = k_q;
  assign BUSY       = run_q;
  assign DONE       = done_q;
  assign ERROR      = err_q;

endmodule

// File: tb/tb_matmul_core_scheduler.sv
module tb_matmul_core_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       start1, start2;
  logic [7:0] d_m, d_n, d_k;

  logic [3:0] dv1, rdy1, cd1;
  logic [7:0] row1, col1, len1;
  logic       busy1, done1, err1;

  logic [1:0] dv2, rdy2, cd2;
  logic [7:0] row2, col2, len2;
  logic       busy2, done2, err2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  matmul_core_scheduler #(.CORES(4)) u_dut1 (
    .CLOCK(clk), .RESET(rst), .START(start1),
    .DIM_M(d_m), .DIM_N(d_n), .DIM_K(d_k),
    .DISP_VALID(dv1), .DISP_ROW(row1), .DISP_COL(col1), .DISP_LEN(len1),
    .CORE_READY(rdy1), .CORE_DONE(cd1),
    .BUSY(busy1), .DONE(done1), .ERROR(err1)
  );

  matmul_core_scheduler #(.CORES(2)) u_dut2 (
    .CLOCK(clk), .RESET(rst), .START(start2),
    .DIM_M(d_m), .DIM_N(d_n), .DIM_K(d_k),
    .DISP_VALID(dv2), .DISP_ROW(row2), .DISP_COL(col2), .DISP_LEN(len2),
    .CORE_READY(rdy2), .CORE_DONE(cd2),
    .BUSY(busy2), .DONE(done2), .ERROR(err2)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Runs one job set. Cores answer CORE_DONE a fixed delay after accepting.
  // first: core expected to take job 0; spur_at: cycle to inject a spurious
  // CORE_DONE[3] (-1 none); hold: cycles to keep CORE_READY low while an
  // offer is visible; abort_at: return once this many jobs are issued (-1 none).
  task automatic run_set(input int sel, input int m, input int n, input int k,
                         input int first, input int spur_at, input int hold,
                         input int abort_at);
    int ncores, jobs, issued, comp, ndone, held, idx;
    int cnt[4];
    bit mb[4];
    logic [3:0] v, rdy, cd, xf;
    logic [7:0] r, c, l;
    logic dn, bz, er;
    ncores = sel ? 2 : 4;
    jobs = m * n; issued = 0; comp = 0; ndone = 0; held = 0;
    for (int i = 0; i < 4; i++) begin cnt[i] = 0; mb[i] = 1'b0; end
    d_m = 8'(m); d_n = 8'(n); d_k = 8'(k);
    if (sel != 0) start2 = 1'b1; else start1 = 1'b1;
    tick;
    start1 = 1'b0; start2 = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      v  = (sel != 0) ? {2'b00, dv2} : dv1;
      r  = (sel != 0) ? row2 : row1;
      c  = (sel != 0) ? col2 : col1;
      l  = (sel != 0) ? len2 : len1;
      dn = (sel != 0) ? done2 : done1;
      bz = (sel != 0) ? busy2 : busy1;
      er = (sel != 0) ? err2 : err1;
      if (abort_at >= 0 && issued == abort_at) break;
      chk("error_pulse", 32'(er), 32'(spur_at >= 0 && cyc == spur_at + 1));
      if (dn) begin
        ndone++;
        chk("done_after_all", comp, jobs);
        chk("busy_at_done", 32'(bz), 0);
        break;
      end
      chk("busy_running", 32'(bz), 1);
      rdy = 4'hF;
      if (v != 4'h0 && held < hold) begin
        rdy = 4'h0;
        held++;
        chk("hold_vld", 32'(v), 1);
        chk("hold_row", 32'(r), 0);
        chk("hold_col", 32'(c), 0);
      end
      cd = 4'h0;
      for (int i = 0; i < ncores; i++) begin
        if (mb[i]) begin
          if (cnt[i] == 1) begin cd[i] = 1'b1; mb[i] = 1'b0; comp++; end
          else cnt[i]--;
        end
      end
      if (cyc == spur_at) cd[3] = 1'b1;
      xf = v & rdy;
      if (xf != 4'h0) begin
        idx = 0;
        for (int i = 0; i < 4; i++) if (xf[i]) idx = i;
        chk("offer_onehot", $countones(v), 1);
        chk("offer_core", idx, (first + issued) % ncores);
        chk("offer_row", 32'(r), issued / n);
        chk("offer_col", 32'(c), issued % n);
        chk("offer_len", 32'(l), k);
        chk("core_was_idle", 32'(mb[idx]), 0);
        mb[idx] = 1'b1;
        cnt[idx] = 5;
        issued++;
      end
      if (sel != 0) begin rdy2 = rdy[1:0]; cd2 = cd[1:0]; end
      else begin rdy1 = rdy; cd1 = cd; end
      tick;
    end
    rdy1 = 4'h0; cd1 = 4'h0; rdy2 = 2'b00; cd2 = 2'b00;
    if (abort_at < 0) begin
      chk("done_count", ndone, 1);
      chk("issued_count", issued, jobs);
      repeat (3) begin
        tick;
        chk("done_once", 32'((sel != 0) ? done2 : done1), 0);
        chk("busy_after_done", 32'((sel != 0) ? busy2 : busy1), 0);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start1 = 1'b0; start2 = 1'b0;
    d_m = 8'd0; d_n = 8'd0; d_k = 8'd0;
    rdy1 = 4'h0; cd1 = 4'h0; rdy2 = 2'b00; cd2 = 2'b00;
    repeat (2) tick;
    chk("rst_vld1", 32'(dv1), 0);
    chk("rst_busy1", 32'(busy1), 0);
    chk("rst_done1", 32'(done1), 0);
    chk("rst_err1", 32'(err1), 0);
    chk("rst_idx1", {8'd0, row1, col1, len1}, 0);
    chk("rst_vld2", 32'(dv2), 0);
    chk("rst_busy2", 32'(busy2), 0);
    rst = 1'b0;
    tick;

    // 2x2, K=3 on four cores: cores 0..3 in order.
    run_set(0, 2, 2, 3, 0, -1, 0, -1);
    // 3x3, K=1 on two cores: alternating, each reused only after its done.
    run_set(1, 3, 3, 1, 0, -1, 0, -1);
    // 1x1 with core 0 withholding ready for 10 cycles.
    run_set(0, 1, 1, 1, 0, -1, 10, -1);

    // Zero N: error pulse one cycle later, nothing dispatched.
    d_m = 8'd2; d_n = 8'd0; d_k = 8'd3;
    start1 = 1'b1;
    tick;
    start1 = 1'b0;
    chk("zero_err", 32'(err1), 1);
    chk("zero_busy", 32'(busy1), 0);
    chk("zero_vld", 32'(dv1), 0);
    chk("zero_done", 32'(done1), 0);
    repeat (4) begin
      tick;
      chk("zero_err_drop", 32'(err1), 0);
      chk("zero_vld_idle", 32'(dv1), 0);
      chk("zero_busy_idle", 32'(busy1), 0);
      chk("zero_done_idle", 32'(done1), 0);
    end

    // Spurious done on idle core 3; pointer was left at 1 by the 1x1 run.
    run_set(0, 2, 2, 2, 1, 0, 0, -1);

    // Reset mid-issue after 2 of 4 jobs (pointer at 1 after previous run).
    run_set(0, 2, 2, 3, 1, -1, 0, 2);
    #2 rst = 1'b1;
    #1;
    chk("async_vld", 32'(dv1), 0);
    chk("async_busy", 32'(busy1), 0);
    chk("async_row", 32'(row1), 0);
    chk("async_col", 32'(col1), 0);
    chk("async_len", 32'(len1), 0);
    chk("async_done_err", {done1, err1}, 0);
    tick;
    rst = 1'b0;
    tick;
    // Restart begins at (0,0) on core 0.
    run_set(0, 2, 2, 3, 0, -1, 0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
